// File: rtl/alu_wb_pkg.sv
// Shared writeback constants: datapath/register widths, drain phase encodings,
// and the layout of one buffered ALU completion.
// Pure declarations; no logic, no latency, no flow control.
package alu_wb_pkg;

    localparam int WB_LEN_DATA = 64;
    localparam int WB_REG_AW   = 5;

    // Drain phase: LO writes result to rd, HI writes ex_result to rd_ex.
    localparam logic WB_PH_LO = 1'b0;
    localparam logic WB_PH_HI = 1'b1;

    // Bit offsets of each field inside a buffered entry (LSB first).
    localparam int WB_RESULT_LSB    = 0;
    localparam int WB_EX_RESULT_LSB = WB_RESULT_LSB + WB_LEN_DATA;
    localparam int WB_COUT_BIT      = WB_EX_RESULT_LSB + WB_LEN_DATA;
    localparam int WB_DUAL_BIT      = WB_COUT_BIT + 1;
    localparam int WB_RD_LSB        = WB_DUAL_BIT + 1;
    localparam int WB_RD_EX_LSB     = WB_RD_LSB + WB_REG_AW;
    localparam int WB_FLAG_WE_BIT   = WB_RD_EX_LSB + WB_REG_AW;
    localparam int WB_ENTRY_W       = WB_FLAG_WE_BIT + 1;

    // Packed view of the same layout; members run MSB to LSB, so result sits at bit 0.
    typedef struct packed {
        logic                   flag_we;
        logic [WB_REG_AW-1:0]   rd_ex;
        logic [WB_REG_AW-1:0]   rd;
        logic                   dual;
        logic                   cout;
        logic [WB_LEN_DATA-1:0] ex_result;
        logic [WB_LEN_DATA-1:0] result;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_fifo.sv
// wb_fifo: generic synchronous FIFO with count/full/empty and async-reset pointers.
// Latency: a push at edge N is visible on pop_data after edge N (first-word fall-through).
// Backpressure: none internally; the caller must only push when !full or popping, and pop when !empty.
//
// Ports: clk, rst_n; push/push_data write side; pop/pop_data read side;
//        count (occupancy), full, empty.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is deliberately left unreset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap with no compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/alu_wb.sv
// alu_wb: buffers ALU completions and drains them to the single register-file write port.
// Latency: entry pushed at edge N is presented the following cycle; dual entries take two write steps.
// Backpressure: stall at DEPTH-1 entries covers the op in flight; writes hold until rf_ack.
//
// Ports: in_* completion from ALU (in_valid qualifies); rf_we/rf_waddr/rf_wdata + rf_ack
//        register-file write port; flag_c carry flag; stall to issue; busy; sticky ovf_err.
module alu_wb
    import alu_wb_pkg::*;
#(
    parameter int LEN_DATA = WB_LEN_DATA,
    parameter int REG_AW   = WB_REG_AW,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [LEN_DATA-1:0] in_result,
    input  logic [LEN_DATA-1:0] in_ex_result,
    input  logic                in_cout,
    input  logic                in_dual,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic [REG_AW-1:0]   in_rd_ex,
    input  logic                in_flag_we,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [LEN_DATA-1:0] rf_wdata,
    input  logic                rf_ack,
    output logic                flag_c,
    output logic                stall,
    output logic                busy,
    output logic                ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 1);

    wb_entry_t      push_ent;
    wb_entry_t      head;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           phase;
    logic           push_ok;
    logic           step_done;
    logic           retire;
    logic [REG_AW-1:0]   cur_rd;
    logic [LEN_DATA-1:0] cur_data;

    assign push_ent = '{flag_we:   in_flag_we,
                        rd_ex:     in_rd_ex,
                        rd:        in_rd,
                        dual:      in_dual,
                        cout:      in_cout,
                        ex_result: in_ex_result,
                        result:    in_result};

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (push_ent),
        .pop       (retire),
        .pop_data  (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Write port is driven purely from the head entry and phase; zero while empty.
    always_comb begin
        cur_rd   = '0;
        cur_data = '0;
        if (!empty) begin
            if (phase == WB_PH_HI) begin
                cur_rd   = head.rd_ex;
                cur_data = head.ex_result;
            end else begin
                cur_rd   = head.rd;
                cur_data = head.result;
            end
        end
    end

    // r0 writes are dropped: the step completes in one cycle without an ack.
    assign step_done = !empty && ((cur_rd == '0) || rf_ack);
    assign retire    = step_done && ((phase == WB_PH_HI) || !head.dual);
    // A full FIFO still accepts when the head retires on the same edge.
    assign push_ok   = in_valid && (!full || retire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= WB_PH_LO;
            flag_c  <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (step_done) begin
                phase <= ((phase == WB_PH_LO) && head.dual) ? WB_PH_HI : WB_PH_LO;
            end
            if (retire && head.flag_we) begin
                flag_c <= head.cout;
            end
            if (in_valid && !push_ok) begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign rf_we    = (cur_rd != '0);
    assign rf_waddr = cur_rd;
    assign rf_wdata = cur_data;
    assign stall    = (count >= STALL_LVL);
    assign busy     = !empty;

endmodule

// File: doc/alu_wb.md
Name: alu_wb

Overview:
- Writeback stage directly downstream of the ALU. Captures each ALU completion (result, ex_result, cout) in a small FIFO.
- Drains entries to the single register-file write port. Dual-result ops (128-bit add/sub, SWR) issue two writes: LO, then HI.
- Owns the architectural carry flag and provides issue-side backpressure through stall.

Parameters:
- LEN_DATA, 64, datapath width (matches the ALU).
- REG_AW, 5, register address width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  ALU rdy; one completion this cycle
- in_result  in  LEN_DATA  ALU result (LO write data)
- in_ex_result  in  LEN_DATA  ALU ex_result (HI write data)
- in_cout  in  1  ALU carry out
- in_dual  in  1  entry needs a second (HI) write
- in_rd  in  REG_AW  LO destination register
- in_rd_ex  in  REG_AW  HI destination register
- in_flag_we  in  1  commit in_cout to flag_c
- rf_we  out  1  register-file write request
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  LEN_DATA  write data
- rf_ack  in  1  write port granted this cycle
- flag_c  out  1  architectural carry flag
- stall  out  1  issue must hold the next ALU op
- busy  out  1  FIFO non-empty or a write is in progress
- ovf_err  out  1  sticky: a completion arrived while the FIFO was full and was dropped

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, phase=LO; flag_c=0, ovf_err=0. All other outputs read 0 while empty. FIFO data storage is not reset.
- Applies mid-drain too: a pending HI write is abandoned and no partial flag update occurs.
- Push: on in_valid, store {result, ex_result, cout, dual, rd, rd_ex, flag_we} at wr_ptr.
  - Accept when count<DEPTH, or when count==DEPTH and a retire occurs the same cycle.
  - Otherwise drop the completion and set ovf_err. ovf_err clears only on reset.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - Simultaneous push and retire: count unchanged.
- stall = (count >= DEPTH-1), registered-free combinational from count. This absorbs the one ALU op already in flight after issue.
- Drain FSM, states LO and HI, acting on the head entry when count!=0:
  - LO: present rd/result. Step completes on rf_we&rf_ack, or immediately if rd==0. A write to r0 is suppressed: rf_we=0, the step takes 1 cycle, no ack needed.
    - On completion: if dual, go to HI; else retire the entry.
  - HI: present rd_ex/ex_result. Same completion rule, including r0 suppression. On completion, retire and return to LO.
  - Retire: rd_ptr+1, count-1. If flag_we, flag_c<=cout in that same edge.
- rf_we/rf_waddr/rf_wdata derive only from the head entry and phase; there is no combinational path from in_* to rf_*.
  - Latency: an entry pushed at edge N is presented in the cycle after N (earliest write at edge N+1).
- rf_ack while rf_we=0 is ignored. rf_waddr and rf_wdata are held stable while rf_we=1 and rf_ack=0.
- Throughput: one single-write entry per cycle under continuous ack; a dual entry takes 2 cycles.
- busy = (count!=0).

Decomposition:
- Shared package/define file (alongside the ALU defines) holds:
  - the LEN_DATA and register-address-width constants;
  - WB_PH_LO=1'b0 and WB_PH_HI=1'b1 phase encodings;
  - the FIFO entry field layout (bit offsets of result, ex_result, cout, dual, rd, rd_ex, flag_we).
- One natural sub-module: wb_fifo, a parameterised synchronous FIFO with push/pop, count, full/empty, and async active-low reset of its pointers. The drain FSM and flag register stay in alu_wb.

Test Plan:
- Single write: in_valid with result=0x1122334455667788, rd=3, flag_we=1, cout=1; rf_ack held 1.
  -> Next cycle rf_we=1, waddr=3, wdata=0x1122334455667788. flag_c=1 after that edge; busy returns to 0.
- Dual write: result=0xA, ex_result=0xB, rd=4, rd_ex=5, dual=1, ack=1.
  -> Two consecutive writes, (4,0xA) then (5,0xB); retire after the second.
- Backpressure: DEPTH=4, push 3 entries with rf_ack=0.
  -> stall=1 at count=3. A 4th push is accepted. A 5th push with no ack sets ovf_err=1 and count stays 4.
  -> Then ack=1: exactly 4 writes in FIFO order.
- r0 suppression: rd=0, dual=1, rd_ex=7, ex_result=0x55, ack=0.
  -> LO step skipped with rf_we=0 for 1 cycle. HI then holds rf_we=1, waddr=7 until ack.
- Full plus simultaneous retire: count=4, head presenting with ack=1, in_valid=1 the same cycle.
  -> Push accepted, count remains 4, ovf_err stays 0.
- Reset mid-drain: dual entry sitting in HI phase, assert rst_n=0 asynchronously (between edges).
  -> rf_we=0, busy=0, stall=0, flag_c=0 immediately. After release, the FIFO is empty and the next push writes normally.
